shift_sub_divider: RTL and testbench

- Iterative restoring (shift-subtract) integer divider; the inverse unit to the team's shift-add multiplier.
- Produces quotient and remainder with RISC-V M-extension semantics: DIV, DIVU, REM, REMU, including the divide-by-zero and signed-overflow cases.
- Sits in the execute stage's multi-cycle functional-unit slot and uses the same start/done level handshake as the multiplier.

---
 rtl/shift_sub_divider.sv | 173 +++++++++++++++++
 tb/tb_shift_sub_divider.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sub_divider.sv
// shift_sub_divider
//   Iterative restoring (shift-subtract) integer divider with RISC-V M-extension
//   semantics (DIV, DIVU, REM, REMU). It produces one quotient bit per clock.
//   It uses the same start/done level handshake as the shift-add multiplier.
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     start      request level, held until done is seen, then dropped
//     div_type   0 = unsigned operands, 1 = signed two's-complement operands
//     a, b       dividend / divisor, sampled on the accepting IDLE cycle
//     quotient   result quotient, 0 unless done
//     remainder  result remainder, 0 unless done
//     done       high while the result is being presented
//
//   Flow: IDLE -> ITER (N cycles) -> SIGN -> DONE -> IDLE.
//   Divide-by-zero goes from IDLE directly to DONE.

module shift_sub_divider #(
    parameter int OPERAND_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     div_type,
    input  logic [OPERAND_WIDTH-1:0] a,
    input  logic [OPERAND_WIDTH-1:0] b,
    output logic [OPERAND_WIDTH-1:0] quotient,
    output logic [OPERAND_WIDTH-1:0] remainder,
    output logic                     done
);

    localparam int N     = OPERAND_WIDTH;
    localparam int CNT_W = $clog2(N);
    localparam logic [N-1:0]     ONE_N    = N'(1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        SIGN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Partial remainder. It always stays below the divisor magnitude, so N bits
    // hold it. The shifted copy below it is N+1 bits wide.
    logic [N-1:0]     rem_r;
    logic [N-1:0]     quo_r;
    logic [N-1:0]     div_r;
    logic [CNT_W-1:0] cnt;
    logic             q_neg;
    logic             r_neg;

    logic             a_neg;
    logic             b_neg;
    logic [N-1:0]     a_mag;
    logic [N-1:0]     b_mag;
    logic             b_zero;
    logic [N:0]       rem_shift;
    logic [N:0]       trial;
    logic             last_iter;

    // Operand magnitudes and the restoring-step arithmetic.
    // The magnitude of the most negative value (2^(N-1)) is still representable
    // as an unsigned N-bit number, so the signed-overflow case needs no special path.
    always_comb begin
        a_neg     = div_type & a[N-1];
        b_neg     = div_type & b[N-1];
        a_mag     = a_neg ? (~a + ONE_N) : a;
        b_mag     = b_neg ? (~b + ONE_N) : b;
        b_zero    = (b == '0);
        rem_shift = {rem_r, quo_r[N-1]};
        trial     = rem_shift - {1'b0, div_r};
        last_iter = (cnt == LAST_CNT);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DONE is only left once start has been dropped.
    // A held start therefore never restarts an operation.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = b_zero ? DONE : ITER;
                end
            end
            ITER: begin
                if (last_iter) begin
                    state_next = SIGN;
                end
            end
            SIGN: begin
                state_next = DONE;
            end
            DONE: begin
                if (!start) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers.
    // Divide-by-zero loads the final results directly and skips SIGN:
    // the quotient becomes all ones, and the remainder is the raw dividend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r <= '0;
            quo_r <= '0;
            div_r <= '0;
            cnt   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        q_neg <= a_neg ^ b_neg;
                        r_neg <= a_neg;
                        div_r <= b_mag;
                        cnt   <= '0;
                        if (b_zero) begin
                            quo_r <= '1;
                            rem_r <= a;
                        end else begin
                            quo_r <= a_mag;
                            rem_r <= '0;
                        end
                    end
                end
                ITER: begin
                    // A negative trial (bit N set) restores the shifted remainder.
                    quo_r <= {quo_r[N-2:0], ~trial[N]};
                    rem_r <= trial[N] ? rem_shift[N-1:0] : trial[N-1:0];
                    cnt   <= cnt + CNT_W'(1);
                end
                SIGN: begin
                    if (q_neg) begin
                        quo_r <= ~quo_r + ONE_N;
                    end
                    if (r_neg) begin
                        rem_r <= ~rem_r + ONE_N;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are gated by state, so an asynchronous reset clears them at once.
    always_comb begin
        done      = (state == DONE);
        quotient  = done ? quo_r : '0;
        remainder = done ? rem_r : '0;
    end

endmodule

// File: tb/tb_shift_sub_divider.sv
// tb_shift_sub_divider
//   Self-checking bench for shift_sub_divider with N = 32.
//   Each operation's expected result goes into a scoreboard queue when it is
//   issued. The entry is popped and compared when done rises.
//   Vectors come from a fixed table plus random operands modelled with
//   native SystemVerilog division. Handshake and reset corner cases are
//   written out by hand.

module tb_shift_sub_divider;

    localparam int N = 32;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         s;
        logic [N-1:0] q;
        logic [N-1:0] r;
        int           lat;
    } vec_t;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        int           lat;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         div_type;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         done;

    int   tests_run;
    int   tests_failed;
    exp_t sb[$];
    vec_t vecs[14];

    shift_sub_divider #(.OPERAND_WIDTH(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .div_type  (div_type),
        .a         (a),
        .b         (b),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and record the outcome
    task automatic checkOutput(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one operation and wait for done, then compare against the scoreboard.
    // Start is raised on a falling edge, and latency counts the rising edges until done.
    // The task returns on the falling edge where done was first seen, with start still held.
    task automatic applyStimulus(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vs,
                                 input logic [N-1:0] eq, input logic [N-1:0] er, input int elat);
        exp_t e;
        int   cycles;
        logic pre_zero;
        @(negedge clk);
        a        = va;
        b        = vb;
        div_type = vs;
        start    = 1'b1;
        sb.push_back('{q: eq, r: er, lat: elat});
        cycles   = 0;
        pre_zero = 1'b1;
        forever begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            // Operands changing mid-operation must be ignored
            a = $urandom;
            b = $urandom;
            div_type = ~div_type;
            if (done) break;
            if (quotient != '0 || remainder != '0) pre_zero = 1'b0;
            if (cycles > 100) break;
        end
        e = sb.pop_front();
        checkOutput("latency", N'(cycles), N'(e.lat));
        checkOutput("outputs zero before done", {31'b0, pre_zero}, 32'd1);
        checkOutput("quotient", quotient, e.q);
        checkOutput("remainder", remainder, e.r);
    endtask

    // Drop start and check that done falls after the next edge
    task automatic releaseStart();
        start = 1'b0;
        @(negedge clk);
        checkOutput("done drops after start low", {31'b0, done}, 32'd0);
    endtask

    initial begin
        logic signed [N-1:0] sa;
        logic signed [N-1:0] sbv;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic [N-1:0] rq;
        logic [N-1:0] rr;
        logic         rs;
        logic [N-1:0] hq;
        logic [N-1:0] hr;

        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        div_type     = 1'b0;
        a            = '0;
        b            = '0;

        vecs[0]  = '{a: 32'd100,        b: 32'd7,          s: 1'b0, q: 32'd14,         r: 32'd2,          lat: 34};
        vecs[1]  = '{a: 32'hFFFFFFF9,   b: 32'd2,          s: 1'b1, q: 32'hFFFFFFFD,   r: 32'hFFFFFFFF,   lat: 34};
        vecs[2]  = '{a: 32'd7,          b: 32'hFFFFFFFE,   s: 1'b1, q: 32'hFFFFFFFD,   r: 32'd1,          lat: 34};
        vecs[3]  = '{a: 32'd5,          b: 32'd0,          s: 1'b0, q: 32'hFFFFFFFF,   r: 32'd5,          lat: 1};
        vecs[4]  = '{a: 32'hFFFFFFFB,   b: 32'd0,          s: 1'b1, q: 32'hFFFFFFFF,   r: 32'hFFFFFFFB,   lat: 1};
        vecs[5]  = '{a: 32'h80000000,   b: 32'hFFFFFFFF,   s: 1'b1, q: 32'h80000000,   r: 32'd0,          lat: 34};
        vecs[6]  = '{a: 32'h80000000,   b: 32'hFFFFFFFF,   s: 1'b0, q: 32'd0,          r: 32'h80000000,   lat: 34};
        vecs[7]  = '{a: 32'd0,          b: 32'd5,          s: 1'b1, q: 32'd0,          r: 32'd0,          lat: 34};
        vecs[8]  = '{a: 32'd0,          b: 32'hFFFFFFFB,   s: 1'b1, q: 32'd0,          r: 32'd0,          lat: 34};
        vecs[9]  = '{a: 32'hFFFFFF9C,   b: 32'hFFFFFFF9,   s: 1'b1, q: 32'd14,         r: 32'hFFFFFFFE,   lat: 34};
        vecs[10] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   s: 1'b0, q: 32'd1,          r: 32'd0,          lat: 34};
        vecs[11] = '{a: 32'h12345678,   b: 32'h00001000,   s: 1'b0, q: 32'h00012345,   r: 32'h00000678,   lat: 34};
        vecs[12] = '{a: 32'h80000000,   b: 32'h00000001,   s: 1'b1, q: 32'h80000000,   r: 32'd0,          lat: 34};
        vecs[13] = '{a: 32'd3,          b: 32'd10,         s: 1'b0, q: 32'd0,          r: 32'd3,          lat: 34};

        // Reset state before any clock edge
        #3;
        checkOutput("reset done", {31'b0, done}, 32'd0);
        checkOutput("reset quotient", quotient, 32'd0);
        checkOutput("reset remainder", remainder, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r, vecs[i].lat);
            releaseStart();
        end

        // Random operands against native signed/unsigned division
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            rs = 1'($urandom_range(0, 1));
            if (rb == '0) rb = 32'd3;
            if (rs && rb == 32'hFFFFFFFF) rb = 32'd3;
            if (rs) begin
                sa  = ra;
                sbv = rb;
                rq  = sa / sbv;
                rr  = sa % sbv;
            end else begin
                rq = ra / rb;
                rr = ra % rb;
            end
            applyStimulus(ra, rb, rs, rq, rr, 34);
            releaseStart();
        end

        // Hold start past done; results must stay put and no restart may occur
        applyStimulus(32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 34);
        hq = 32'd30;
        hr = 32'd10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("held done", {31'b0, done}, 32'd1);
            checkOutput("held quotient", quotient, hq);
            checkOutput("held remainder", remainder, hr);
        end
        releaseStart();
        applyStimulus(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 34);
        releaseStart();

        // Asynchronous reset in the middle of the iterations
        @(negedge clk);
        a = 32'd100;
        b = 32'd7;
        div_type = 1'b0;
        start = 1'b1;
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid-iter reset done", {31'b0, done}, 32'd0);
        checkOutput("mid-iter reset quotient", quotient, 32'd0);
        checkOutput("mid-iter reset remainder", remainder, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 34);

        // Asynchronous reset while results are presented clears them with no edge
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("done-state reset done", {31'b0, done}, 32'd0);
        checkOutput("done-state reset quotient", quotient, 32'd0);
        checkOutput("done-state reset remainder", remainder, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        checkOutput("scoreboard empty", N'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
